apb_master_bridge: RTL and testbench

- Converts a simple core-side request/grant/response interface into APB master transfers on one apb_bus_t master port.
- Sits between a CPU data port or DMA and the APB interconnect. It is the initiating end of the bus that the interconnect routes to the slaves.
- One outstanding transfer at a time. Back-to-back transfers are supported.

---
 rtl/apb_master_bridge_if.sv | 26 ++
 rtl/apb_master_bridge.sv | 135 +++++++++++++
 tb/tb_apb_master_bridge.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// APB signal bundle between the bridge (master end) and the interconnect/slaves.
interface apb_bus_t #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  PCLK;
  logic                  PRESETn;
  logic                  PSEL;
  logic                  PENABLE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PCLK, PRESETn, PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PCLK, PRESETn, PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Core req/gnt/rvalid port to APB master bridge, one transfer in flight.
// Define APB_TIMEOUT_EN to abort ACCESS phases that wait longer than TIMEOUT_CYCLES.
module apb_master_bridge #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  apb_bus_t.master                  master_port
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic                      psel_q, penable_q, pwrite_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [APB_DATA_WIDTH-1:0] pwdata_q;
  logic                      rvalid_q, err_q;
  logic [APB_DATA_WIDTH-1:0] rdata_q;
  logic                      complete;
  logic                      timeout;

`ifdef APB_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] wait_cnt_q;

  assign timeout = (state_q == ACCESS) && !master_port.PREADY && (wait_cnt_q == CntMax);

  // Counts ACCESS cycles already spent waiting; restarts with every new SETUP.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
    end else if (state_d == SETUP) begin
      wait_cnt_q <= '0;
    end else if ((state_q == ACCESS) && !master_port.PREADY && !timeout) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    gnt_o    = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (timeout) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (master_port.PREADY) begin
          complete = 1'b1;
          gnt_o    = req_i;
          state_d  = req_i ? SETUP : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= (state_d != IDLE);
      penable_q <= (state_d == ACCESS);
      if (gnt_o) begin
        paddr_q  <= addr_i;
        pwrite_q <= we_i;
        pwdata_q <= wdata_i;
      end
    end
  end

  // Response registers hold their value between completions.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= complete;
      if (complete) begin
        err_q   <= timeout | master_port.PSLVERR;
        rdata_q <= (timeout || pwrite_q) ? '0 : master_port.PRDATA;
      end
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

  assign master_port.PCLK    = clk;
  assign master_port.PRESETn = ~rst_i;
  assign master_port.PSEL    = psel_q;
  assign master_port.PENABLE = penable_q;
  assign master_port.PADDR   = paddr_q;
  assign master_port.PWRITE  = pwrite_q;
  assign master_port.PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: slave model with memory, error region and wait states.
module tb_apb_master_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_i = 1'b0;
  logic          we_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [DW-1:0] wdata_i = '0;
  logic          gnt_o, rvalid_o, err_o;
  logic [DW-1:0] rdata_o;

  apb_bus_t #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_master_bridge #(
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .err_o      (err_o),
    .master_port(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- slave model ----------------
  logic [DW-1:0] smem    [256];
  logic [DW-1:0] ref_mem [256];
  bit  hold_low   = 1'b0;
  bit  rand_waits = 1'b0;
  int  fixed_waits = 0;
  int  cur_waits   = 0;
  int  wcnt        = 0;

  wire access  = bus.PSEL && bus.PENABLE;
  wire slv_err = (bus.PADDR[13:12] == 2'b11);
  assign bus.PREADY  = access && !hold_low && (wcnt >= cur_waits);
  assign bus.PSLVERR = access && slv_err;
  assign bus.PRDATA  = (access && !bus.PWRITE) ? smem[bus.PADDR[9:2]] : 32'hA5A5_A5A5;

  always @(posedge clk) begin
    if (bus.PSEL && !bus.PENABLE) begin
      cur_waits <= rand_waits ? int'($urandom_range(0, 3)) : fixed_waits;
      wcnt      <= 0;
    end else if (access) begin
      if (bus.PREADY) begin
        if (bus.PWRITE && !slv_err) smem[bus.PADDR[9:2]] <= bus.PWDATA;
        wcnt <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            gcyc;
    int            lat;
  } resp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } req_t;

  resp_t sb_q[$];
  req_t  apb_q[$];
  req_t  cur_req;
  resp_t mon_r;
  int    rv_count   = 0;
  bit    b2b_win    = 1'b0;
  int    psel_drops = 0;

  always @(negedge clk) begin
    if (!rst_i) begin
      if (rvalid_o) begin
        rv_count++;
        if (sb_q.size() == 0) begin
          check("unexpected_rvalid", 1, 0);
        end else begin
          mon_r = sb_q.pop_front();
          check("rdata", rdata_o, mon_r.rdata);
          check("err", err_o, mon_r.err);
          if (mon_r.lat >= 0) check("latency", cyc - mon_r.gcyc, mon_r.lat);
        end
      end
      check("penable_without_psel", bus.PENABLE && !bus.PSEL, 0);
      if (bus.PSEL && !bus.PENABLE) begin
        if (apb_q.size() == 0) begin
          check("unexpected_setup", 1, 0);
        end else begin
          cur_req = apb_q.pop_front();
          check("setup_paddr", bus.PADDR, cur_req.addr);
          check("setup_pwrite", bus.PWRITE, cur_req.we);
          check("setup_pwdata", bus.PWDATA, cur_req.wdata);
        end
      end else if (access) begin
        check("access_paddr", bus.PADDR, cur_req.addr);
        check("access_pwrite", bus.PWRITE, cur_req.we);
        check("access_pwdata", bus.PWDATA, cur_req.wdata);
      end
      if (b2b_win && !bus.PSEL) psel_drops++;
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input int lat, input bit expect_resp, input bit tmo, output int gcyc);
    resp_t r;
    req_t  q;
    int    n = 0;
    int    idx;
    logic  e;
    @(negedge clk);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd;
    #1;
    while (!gnt_o) begin
      n++;
      if (n > 300) begin
        check("grant_wait", 0, 1);
        req_i = 1'b0;
        gcyc = -1;
        return;
      end
      @(negedge clk);
      #1;
    end
    gcyc = cyc;
    q = '{addr: addr, we: we, wdata: wd};
    apb_q.push_back(q);
    if (expect_resp) begin
      idx = int'(addr[9:2]);
      e   = (addr[13:12] == 2'b11);
      if (tmo) begin
        r = '{rdata: '0, err: 1'b1, gcyc: gcyc, lat: lat};
      end else begin
        r = '{rdata: (we ? '0 : ref_mem[idx]), err: e, gcyc: gcyc, lat: lat};
        if (we && !e) ref_mem[idx] = wd;
      end
      sb_q.push_back(r);
    end
  endtask

  task automatic drop();
    @(negedge clk);
    req_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int gb[4];
    int rc;
    logic [DW-1:0] v;

    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      smem[i] = v;
      ref_mem[i] = v;
    end

    // Reset state
    @(negedge clk);
    check("rst_psel", bus.PSEL, 0);
    check("rst_penable", bus.PENABLE, 0);
    check("rst_pwrite", bus.PWRITE, 0);
    check("rst_paddr", bus.PADDR, 0);
    check("rst_pwdata", bus.PWDATA, 0);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_err", err_o, 0);
    check("rst_presetn", bus.PRESETn, 0);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("presetn_released", bus.PRESETn, 1);

    // Single write with PREADY already high
    issue(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 3, 1'b1, 1'b0, g);
    drop();
    check("sw_psel_t1", bus.PSEL, 1);
    check("sw_penable_t1", bus.PENABLE, 0);
    check("sw_paddr_t1", bus.PADDR, 32'h0000_1004);
    check("sw_pwdata_t1", bus.PWDATA, 32'hDEAD_BEEF);
    @(negedge clk);
    check("sw_penable_t2", bus.PENABLE, 1);
    repeat (3) @(negedge clk);

    // Read with 3 wait states, data written beforehand
    issue(1'b1, 32'h0000_0040, 32'h1234_5678, 3, 1'b1, 1'b0, g);
    drop();
    repeat (3) @(negedge clk);
    fixed_waits = 3;
    issue(1'b0, 32'h0000_0040, $urandom, 6, 1'b1, 1'b0, g);
    drop();
    repeat (7) @(negedge clk);
    check("wait_read_rdata", rdata_o, 32'h1234_5678);
    fixed_waits = 0;

    // Four back-to-back transfers
    rc = rv_count;
    for (int i = 0; i < 4; i++) begin
      issue(1'(i % 2), $urandom & 32'h0000_03FC, $urandom, 3, 1'b1, 1'b0, gb[i]);
      if (i == 0) b2b_win = 1'b1;
    end
    drop();
    @(negedge clk);
    #1 b2b_win = 1'b0;
    for (int i = 1; i < 4; i++) check("b2b_grant_spacing", gb[i] - gb[i-1], 2);
    repeat (3) @(negedge clk);
    check("b2b_psel_drops", psel_drops, 0);
    check("b2b_rvalid_count", rv_count - rc, 4);

    // Slave error followed by a clean read
    issue(1'b0, 32'h0000_3010, '0, 3, 1'b1, 1'b0, g);
    drop();
    repeat (2) @(negedge clk);
    issue(1'b0, 32'h0000_0010, '0, 3, 1'b1, 1'b0, g);
    drop();
    repeat (4) @(negedge clk);

    // Reset while the slave stalls in ACCESS
    hold_low = 1'b1;
    issue(1'b0, 32'h0000_0020, '0, -1, 1'b0, 1'b0, g);
    drop();
    @(negedge clk);
    check("pre_reset_access", access, 1);
    rc = rv_count;
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_psel", bus.PSEL, 0);
    check("async_rst_penable", bus.PENABLE, 0);
    check("async_rst_rvalid", rvalid_o, 0);
    check("async_rst_rdata", rdata_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    hold_low = 1'b0;
    repeat (5) @(negedge clk);
    check("no_rvalid_after_reset", rv_count - rc, 0);
    issue(1'b1, 32'h0000_0044, $urandom, 3, 1'b1, 1'b0, g);
    drop();
    repeat (4) @(negedge clk);

    // Slave that never raises PREADY
    rc = rv_count;
    hold_low = 1'b1;
`ifdef APB_TIMEOUT_EN
    issue(1'b0, 32'h0000_0080, '0, 3 + TO, 1'b1, 1'b1, g);
    drop();
    repeat (TO + 6) @(negedge clk);
    check("timeout_rvalid_count", rv_count - rc, 1);
    check("timeout_idle_psel", bus.PSEL, 0);
    hold_low = 1'b0;
`else
    issue(1'b0, 32'h0000_0080, '0, -1, 1'b1, 1'b0, g);
    drop();
    repeat (100) @(negedge clk);
    check("hang_no_rvalid", rv_count - rc, 0);
    check("hang_still_access", access, 1);
    hold_low = 1'b0;
    repeat (4) @(negedge clk);
    check("hang_released_rvalid", rv_count - rc, 1);
`endif

    // Randomized traffic with random waits, gaps and error region hits
    rand_waits = 1'b1;
    for (int i = 0; i < 60; i++) begin
      issue(1'($urandom), $urandom & 32'h0000_33FC, $urandom, -1, 1'b1, 1'b0, g);
      if ($urandom_range(0, 2) == 0) begin
        drop();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    drop();
    repeat (20) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    check("apb_queue_drained", apb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
